// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the ram_dma block-copy/fill initiator.
package ram_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ram_dma_state_e;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } ram_dma_mode_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/ram_dma_addr_gen.sv
// Loadable word-aligned byte address register with a +WORD_BYTES step that
// wraps modulo 2^ADDR_WIDTH.
module ram_dma_addr_gen
    import ram_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  unused_low;

    // Low bits are dropped on load so every access stays word aligned.
    assign unused_low = ^load_addr_i[1:0];

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = {load_addr_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (inc_i) begin
            addr_d = addr_q + ADDR_WIDTH'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/ram_dma.sv
// Single-port RAM initiator for block copy / block fill.
// Optional RAM_DMA_CHECKSUM_EN adds a rotate-xor checksum of written data.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [31:0]           fill_data_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           wdata_o,
    output logic                  we_o,
    output logic [3:0]            be_o,
    input  logic [31:0]           rdata_i,
    output logic [31:0]           checksum_o
);

    ram_dma_state_e        state_q, state_d;
    ram_dma_mode_e         mode_q;
    logic [31:0]           fill_q;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] src_addr, dst_addr;
    logic                  start_acc;
    logic                  in_read, in_write;

    assign start_acc = (state_q == IDLE) && start_i;
    assign in_read   = (state_q == READ);
    assign in_write  = (state_q == WRITE);

    ram_dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_src (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (start_acc),
        .load_addr_i (src_addr_i),
        .inc_i       (in_read),
        .addr_o      (src_addr)
    );

    ram_dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (start_acc),
        .load_addr_i (dst_addr_i),
        .inc_i       (in_write),
        .addr_o      (dst_addr)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d = len_i;
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = mode_i ? WRITE : READ;
                    end
                end
            end
            READ: begin
                state_d = abort_i ? IDLE : WRITE;
            end
            WRITE: begin
                rem_d = rem_q - 1'b1;
                if (abort_i) begin
                    state_d = IDLE;
                end else if (rem_q == LEN_WIDTH'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = (mode_q == FILL) ? WRITE : READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= COPY;
            fill_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (start_acc) begin
                mode_q <= ram_dma_mode_e'(mode_i);
                fill_q <= fill_data_i;
            end
        end
    end

    // Everything the RAM sees is a pure decode of the registered state.
    assign busy_o  = in_read || in_write;
    assign done_o  = (state_q == DONE);
    assign en_o    = busy_o;
    assign we_o    = in_write;
    assign be_o    = in_write ? 4'hF : 4'h0;
    assign addr_o  = in_read ? src_addr : (in_write ? dst_addr : '0);
    assign wdata_o = !in_write ? 32'h0 : ((mode_q == FILL) ? fill_q : rdata_i);

`ifdef RAM_DMA_CHECKSUM_EN
    logic [31:0] cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q <= '0;
        end else if (start_acc) begin
            cs_q <= '0;
        end else if (in_write) begin
            cs_q <= {cs_q[30:0], cs_q[31]} ^ wdata_o;
        end
    end

    assign checksum_o = cs_q;
`else
    assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma: bench-side RAM, queue-based transaction model
// checked every cycle, plus literal expectations for each scenario.
module tb_ram_dma;

    localparam int AW = 8;
    localparam int LW = 8;
`ifdef RAM_DMA_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i, mode_i, abort_i;
    logic [AW-1:0] src_addr_i, dst_addr_i;
    logic [LW-1:0] len_i;
    logic [31:0]   fill_data_i;
    logic          busy_o, done_o, en_o, we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o, rdata_i, checksum_o;
    logic [3:0]    be_o;

    always #5 clk = ~clk;

    ram_dma #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .len_i       (len_i),
        .fill_data_i (fill_data_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .en_o        (en_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .we_o        (we_o),
        .be_o        (be_o),
        .rdata_i     (rdata_i),
        .checksum_o  (checksum_o)
    );

    // Bench RAM port: registered read, byte-enabled write, plus a backdoor
    // load port so all memory writes stay in one process.
    logic [31:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (en_o) begin
            if (we_o) begin
                mem[addr_o[7:2]] <= (mem[addr_o[7:2]] & ~{{8{be_o[3]}}, {8{be_o[2]}}, {8{be_o[1]}}, {8{be_o[0]}}})
                                  | (wdata_o & {{8{be_o[3]}}, {8{be_o[2]}}, {8{be_o[1]}}, {8{be_o[0]}}});
            end else begin
                rdata_i <= mem[addr_o[7:2]];
            end
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: an accepted start expands into the list of per-cycle bus
    // transactions the transfer must produce; one entry is consumed per cycle.
    typedef struct {
        int          kind;   // 0 idle, 1 read, 2 write, 3 done
        logic [7:0]  addr;
        logic [7:0]  src;
        bit          copy;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] cs_m;

    always @(negedge clk) begin
        ent_t        e;
        bit          popped;
        logic [31:0] d;
        logic [47:0] exp;
        logic [7:0]  s, t;
        if (!rst_n) begin
            q.delete();
            cs_m = 32'h0;
        end else begin
            if (bd_we) ref_mem[bd_idx] = bd_data;
            e = '{kind: 0, addr: 8'h0, src: 8'h0, copy: 1'b0, data: 32'h0};
            popped = 1'b0;
            if (q.size() > 0) begin
                e = q.pop_front();
                popped = 1'b1;
            end
            d = e.copy ? ref_mem[e.src[7:2]] : e.data;
            case (e.kind)
                1:       exp = {1'b1, 1'b0, 4'h0, e.addr, 32'h0, 1'b1, 1'b0};
                2:       exp = {1'b1, 1'b1, 4'hF, e.addr, d, 1'b1, 1'b0};
                3:       exp = {1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 1'b1};
                default: exp = '0;
            endcase
            chk("bus", 64'({en_o, we_o, be_o, addr_o, wdata_o, busy_o, done_o}), 64'(exp));
            chk("checksum", 64'(checksum_o), 64'(CS_EN ? cs_m : 32'h0));
            if (e.kind == 2) begin
                ref_mem[e.addr[7:2]] = d;
                cs_m = {cs_m[30:0], cs_m[31]} ^ d;
            end
            if (popped && e.kind != 3 && abort_i) q.delete();
            if (!popped && start_i) begin
                cs_m = 32'h0;
                s = {src_addr_i[7:2], 2'b00};
                t = {dst_addr_i[7:2], 2'b00};
                for (int i = 0; i < int'(len_i); i++) begin
                    if (!mode_i) q.push_back('{kind: 1, addr: s, src: 8'h0, copy: 1'b0, data: 32'h0});
                    q.push_back('{kind: 2, addr: t, src: s, copy: !mode_i, data: fill_data_i});
                    s = s + 8'd4;
                    t = t + 8'd4;
                end
                q.push_back('{kind: 3, addr: 8'h0, src: 8'h0, copy: 1'b0, data: 32'h0});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic m, input logic [7:0] s, input logic [7:0] d,
                      input logic [7:0] n, input logic [31:0] f);
        mode_i = m; src_addr_i = s; dst_addr_i = d; len_i = n; fill_data_i = f;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Counts cycles from the start cycle to done_o and busy cycles seen.
    task automatic wait_done(output int n, output int nb);
        n = 0;
        nb = 0;
        while (n < 200) begin
            n++;
            if (busy_o) nb++;
            if (done_o) break;
            step();
        end
    endtask

    int n, nb;

    initial begin
        start_i = 0; mode_i = 0; abort_i = 0; src_addr_i = 0; dst_addr_i = 0;
        len_i = 0; fill_data_i = 0; bd_we = 0; bd_idx = 0; bd_data = 0;
        step();
        chk("reset_outputs", 64'({en_o, we_o, be_o, addr_o, wdata_o, busy_o, done_o}), 64'h0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) begin
            bd_we = 1'b1; bd_idx = 6'(i); bd_data = 32'hA500_0000 | i;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            bd_idx = 6'(4 + i); bd_data = 32'h1111_1111 * (i + 1);
            step();
        end
        bd_we = 1'b0;
        step();

        // copy 4 words 0x10 -> 0x80
        go(1'b0, 8'h10, 8'h80, 8'd4, 32'h0);
        wait_done(n, nb);
        chk("copy_done_cycle", 64'(n), 64'd9);
        chk("copy_busy_cycles", 64'(nb), 64'd8);
        step();
        chk("copy_word0", 64'(mem[32]), 64'h1111_1111);
        chk("copy_word3", 64'(mem[35]), 64'h4444_4444);

        // fill 3 words at 0x20
        go(1'b1, 8'h00, 8'h21, 8'd3, 32'hDEAD_BEEF);
        wait_done(n, nb);
        chk("fill_done_cycle", 64'(n), 64'd4);
        step();
        chk("fill_word2", 64'(mem[10]), 64'hDEAD_BEEF);
        chk("fill_past_end", 64'(mem[11]), 64'hA500_000B);

        // zero length
        go(1'b0, 8'h10, 8'h40, 8'd0, 32'h0);
        wait_done(n, nb);
        chk("zero_done_cycle", 64'(n), 64'd1);
        chk("zero_busy_cycles", 64'(nb), 64'd0);
        step();

        // fill across address wrap
        go(1'b1, 8'h00, 8'hF8, 8'd4, 32'hCAFE_F00D);
        wait_done(n, nb);
        chk("wrap_done_cycle", 64'(n), 64'd5);
        step();
        chk("wrap_word_fc", 64'(mem[63]), 64'hCAFE_F00D);
        chk("wrap_word_04", 64'(mem[1]), 64'hCAFE_F00D);
        chk("wrap_word_08", 64'(mem[2]), 64'hA500_0002);

        // abort during 3rd write of an 8-word copy, then restart at once
        go(1'b0, 8'h40, 8'hC0, 8'd8, 32'h0);
        repeat (5) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_idle", 64'({busy_o, done_o, en_o}), 64'h0);
        go(1'b1, 8'h00, 8'h30, 8'd1, 32'h1234_5678);
        wait_done(n, nb);
        chk("restart_done_cycle", 64'(n), 64'd2);
        step();
        chk("abort_word2", 64'(mem[50]), 64'hA500_0012);
        chk("abort_word3", 64'(mem[51]), 64'hA500_0033);
        chk("restart_word", 64'(mem[12]), 64'h1234_5678);

        // overlapping forward copy replicates the first source word
        go(1'b0, 8'h10, 8'h14, 8'd3, 32'h0);
        wait_done(n, nb);
        step();
        chk("overlap_word", 64'(mem[7]), 64'h1111_1111);

        // asynchronous reset in the middle of a fill
        go(1'b1, 8'h00, 8'h00, 8'd8, 32'h0000_0055);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", 64'({en_o, we_o, busy_o}), 64'h0);
        chk("async_reset_cs", 64'(checksum_o), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        go(1'b1, 8'h00, 8'h00, 8'd1, 32'h0000_0001);
        wait_done(n, nb);
        step();
        chk("cs_after_fill", 64'(checksum_o), CS_EN ? 64'h1 : 64'h0);
        step();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
Name: ram_dma

Overview:
Single-port memory initiator that drives one port of the testbench dual-port RAM to perform block copy or block fill without core involvement. It sits beside the core in the verilator model and is started by a testbench or harness register interface. It owns the RAM port's en/addr/wdata/we/be signals and consumes the RAM's registered read data, which arrives one cycle after a read.

Parameters:
ADDR_WIDTH, 8, width of the byte address driven to the RAM port (word-aligned; bits [1:0] always 0)
LEN_WIDTH, 8, width of the transfer length in 32-bit words

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start pulse; operands sampled when start_i=1 in IDLE
mode_i  in  1  0 = copy, 1 = fill
src_addr_i  in  ADDR_WIDTH  copy source byte address; bits [1:0] ignored
dst_addr_i  in  ADDR_WIDTH  destination byte address; bits [1:0] ignored
len_i  in  LEN_WIDTH  number of words to transfer
fill_data_i  in  32  fill pattern, sampled at start
abort_i  in  1  abandon transfer
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse on normal completion
en_o  out  1  RAM port enable
addr_o  out  ADDR_WIDTH  RAM byte address
wdata_o  out  32  RAM write data
we_o  out  1  RAM write enable
be_o  out  4  RAM byte enables; always 4'hF when we_o=1, else 4'h0
rdata_i  in  32  RAM read data, valid the cycle after a read request

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state IDLE. busy_o, done_o, en_o and we_o are 0. addr_o and wdata_o are 0. be_o is 0. All internal registers are cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE, start_i=1:
  - Latch src, dst, len, mode and fill with the address low bits forced to 0.
  - If len=0, go to DONE (no RAM access).
  - Otherwise go to READ for copy, or WRITE for fill.
- start_i while busy is ignored.
- READ (copy only):
  - en_o=1, we_o=0, addr_o=src.
  - Next state WRITE; src += 4.
- WRITE:
  - en_o=1, we_o=1, be_o=4'hF, addr_o=dst.
  - wdata_o = rdata_i for copy, or the latched fill value for fill.
  - dst += 4 and remaining -= 1.
  - If remaining becomes 0, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
- busy_o=1 exactly in READ and WRITE.
- Throughput and latency:
  - Copy takes 2 cycles per word; fill takes 1 cycle per word.
  - done_o asserts the cycle after the last write.
  - Copy of N words has done_o at cycle 2N+1 after the start cycle; fill has done_o at cycle N+1.
- Address wrap: increments are modulo 2^ADDR_WIDTH, with no error.
- Overlap: transfers are strictly a forward word-by-word copy, each read immediately followed by its write. With dst > src and overlapping ranges, the block replicates the source pattern; this is defined behaviour.
- abort_i in READ or WRITE:
  - The current cycle's RAM access still completes as driven.
  - Next state is IDLE with no done_o.
  - abort_i in IDLE or DONE has no effect.
- abort_i and start_i together in IDLE: start wins.
- Outputs are registered-state decodes. en_o is never asserted in IDLE or DONE.

Optional Feature:
RAM_DMA_CHECKSUM_EN:
- Defined: adds output checksum_o[31:0].
  - Cleared on accepted start.
  - In each WRITE cycle, updated as checksum = {checksum[30:0], checksum[31]} ^ wdata_o.
  - Holds its value after DONE or abort until the next start.
- Undefined: no checksum logic; checksum_o exists and is tied to 32'h0.

Decomposition:
- Package ram_dma_pkg:
  - State enum ram_dma_state_e (IDLE, READ, WRITE, DONE).
  - Mode enum ram_dma_mode_e (COPY=0, FILL=1).
  - Constant WORD_BYTES=4.
- Sub-module ram_dma_addr_gen: loadable address register with +4 modulo increment. Instantiated twice, for src and dst.

Test Plan:
1. Copy: preload words 0x11111111..0x44444444 at 0x10; start copy src=0x10 dst=0x80 len=4 -> words appear at 0x80..0x8C; done_o at cycle 9 after start; busy_o high for 8 cycles.
2. Fill: fill dst=0x20 len=3 fill=0xDEADBEEF -> 0x20, 0x24 and 0x28 hold 0xDEADBEEF, 0x2C is unchanged; done_o at cycle 4.
3. Zero length: len=0 -> no en_o assertion, done_o the cycle after start, busy_o never high.
4. Wrap: ADDR_WIDTH=8, fill dst=0xF8 len=4 -> writes to 0xF8, 0xFC, 0x00 and 0x04.
5. Abort: copy len=8, assert abort_i during the 3rd WRITE -> exactly 3 words written; IDLE next cycle; no done_o; a new start is accepted immediately.
6. Reset mid-operation: deassert rst_n during fill -> en_o, we_o and busy_o drop asynchronously; with RAM_DMA_CHECKSUM_EN defined, checksum_o is 0; after fill of len=1 with 0x00000001, checksum_o = 0x00000001.
